// File: rtl/pad_serial_emulator_pkg.sv
// Shared types and constants for the NES/SNES controller shift-register emulator.
// Defines the frame modes, FSM states, frame lengths and button bit positions.
package pad_pkg;

  typedef enum logic {
    PAD_NES  = 1'b0,
    PAD_SNES = 1'b1
  } pad_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } pad_state_e;

  localparam int unsigned NES_BITS  = 32'd8;
  localparam int unsigned SNES_BITS = 32'd16;

  localparam int unsigned NES_A     = 32'd0;
  localparam int unsigned NES_B     = 32'd1;
  localparam int unsigned NES_SEL   = 32'd2;
  localparam int unsigned NES_START = 32'd3;
  localparam int unsigned NES_UP    = 32'd4;
  localparam int unsigned NES_DOWN  = 32'd5;
  localparam int unsigned NES_LEFT  = 32'd6;
  localparam int unsigned NES_RIGHT = 32'd7;

  localparam int unsigned SNES_B     = 32'd0;
  localparam int unsigned SNES_Y     = 32'd1;
  localparam int unsigned SNES_SEL   = 32'd2;
  localparam int unsigned SNES_START = 32'd3;
  localparam int unsigned SNES_UP    = 32'd4;
  localparam int unsigned SNES_DOWN  = 32'd5;
  localparam int unsigned SNES_LEFT  = 32'd6;
  localparam int unsigned SNES_RIGHT = 32'd7;
  localparam int unsigned SNES_A     = 32'd8;
  localparam int unsigned SNES_X     = 32'd9;
  localparam int unsigned SNES_L     = 32'd10;
  localparam int unsigned SNES_R     = 32'd11;

  function automatic int unsigned frame_bits(pad_mode_e m);
    if (m == PAD_SNES) begin
      return SNES_BITS;
    end else begin
      return NES_BITS;
    end
  endfunction

endpackage

// File: rtl/pad_serial_emulator_if.sv
// Console-port and button-board signals of the pad emulator.
// master drives the console/button side, slave is the emulator itself.
interface pad_serial_emulator_if
  import pad_pkg::*;
#(
  parameter int unsigned MAX_BITS = 32'd16
);
  pad_mode_e           mode;
  logic [MAX_BITS-1:0] buttons;
  logic                pad_latch;
  logic                pad_clock;
  logic                pad_data;
  logic                poll_strobe;
  logic                connected;

  modport master (
    output mode, buttons, pad_latch, pad_clock,
    input  pad_data, poll_strobe, connected
  );

  modport slave (
    input  mode, buttons, pad_latch, pad_clock,
    output pad_data, poll_strobe, connected
  );
endinterface

// File: rtl/pad_serial_emulator_sync_edge.sv
// Multi-flop synchroniser for one asynchronous console line, followed by a
// history flop that yields one-clk rise and fall pulses.
module pad_sync_edge #(
  parameter int unsigned SYNC_STAGES = 32'd2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   level_s;

  // synchroniser chain and edge-history flop
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= '0;
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
      prev_r <= level_s;
    end
  end

  assign level_s = sync_r[SYNC_STAGES-1];
  assign rise    = level_s & ~prev_r;
  assign fall    = ~level_s & prev_r;
endmodule

// File: rtl/pad_serial_emulator.sv
// NES/SNES controller emulator: loads synchronised buttons while the console
// latches and shifts them out on console clock rises, all in the board clock.
module pad_serial_emulator
  import pad_pkg::*;
#(
  parameter int unsigned MAX_BITS       = 32'd16,
  parameter int unsigned SYNC_STAGES    = 32'd2,
  parameter int unsigned TIMEOUT_CYCLES = 32'd2_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  pad_serial_emulator_if.slave  pad_if
);
  localparam int unsigned CNT_W = $clog2(MAX_BITS + 32'd1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 32'd1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

  logic                latch_rise_s;
  logic                latch_fall_s;
  logic                clock_rise_s;
  logic                clock_fall_unused_s;

  logic [MAX_BITS-1:0] btn_sync_r [SYNC_STAGES];
  logic [MAX_BITS-1:0] btn_sync_s;
  logic [MAX_BITS-1:0] mask_s;
  logic [CNT_W-1:0]    mode_len_s;

  pad_state_e          state_r, state_s;
  logic [MAX_BITS-1:0] sreg_r, sreg_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [CNT_W-1:0]    frame_len_r, frame_len_s;
  logic                poll_strobe_s;
  logic                pad_data_s;

  logic                pad_data_r;
  logic                poll_strobe_r;
  logic                connected_r;
  logic [TMO_W-1:0]    tmo_cnt_r;

  pad_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (pad_if.pad_latch),
    .rise     (latch_rise_s),
    .fall     (latch_fall_s)
  );

  pad_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clock_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (pad_if.pad_clock),
    .rise     (clock_rise_s),
    .fall     (clock_fall_unused_s)
  );

  // plain synchroniser chain for the button bus
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        btn_sync_r[i] <= '0;
      end
    end else begin
      btn_sync_r[0] <= pad_if.buttons;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        btn_sync_r[i] <= btn_sync_r[i-1];
      end
    end
  end

  assign btn_sync_s = btn_sync_r[SYNC_STAGES-1];

  // SNES length is clamped so a narrow build never counts past its register
  assign mode_len_s = (frame_bits(pad_if.mode) > MAX_BITS) ? CNT_W'(MAX_BITS)
                                                            : CNT_W'(frame_bits(pad_if.mode));

  // keep only the bits belonging to the current frame length
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < int'(MAX_BITS); i++) begin
      mask_s[i] = (CNT_W'(i) < frame_len_r);
    end
  end

  // FSM state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      sreg_r        <= '0;
      cnt_r         <= '0;
      frame_len_r   <= CNT_W'(NES_BITS);
      poll_strobe_r <= 1'b0;
      pad_data_r    <= 1'b1;
    end else begin
      state_r       <= state_s;
      sreg_r        <= sreg_s;
      cnt_r         <= cnt_s;
      frame_len_r   <= frame_len_s;
      poll_strobe_r <= poll_strobe_s;
      pad_data_r    <= pad_data_s;
    end
  end

  // next state; a latch rise aborts whatever frame is in progress
  always_comb begin
    state_s       = state_r;
    sreg_s        = sreg_r;
    cnt_s         = cnt_r;
    frame_len_s   = frame_len_r;
    poll_strobe_s = 1'b0;
    if (latch_rise_s) begin
      state_s     = LOAD;
      frame_len_s = mode_len_s;
      cnt_s       = '0;
    end else begin
      case (state_r)
        IDLE: state_s = IDLE;
        LOAD: begin
          if (latch_fall_s) begin
            cnt_s   = '0;
            state_s = SHIFT;
          end else begin
            sreg_s = btn_sync_s & mask_s;
          end
        end
        SHIFT: begin
          if (clock_rise_s) begin
            sreg_s = {1'b0, sreg_r[MAX_BITS-1:1]};
            cnt_s  = cnt_r + CNT_W'(1);
            if (cnt_s == frame_len_r) begin
              poll_strobe_s = 1'b1;
              state_s       = DONE;
            end else begin
              state_s = SHIFT;
            end
          end else begin
            state_s = SHIFT;
          end
        end
        DONE:    state_s = DONE;
        default: state_s = IDLE;
      endcase
    end
  end

  // wire level is active-low; after the last bit a real pad returns 1s (line low)
  always_comb begin
    pad_data_s = 1'b1;
    case (state_r)
      IDLE:    pad_data_s = 1'b1;
      LOAD:    pad_data_s = ~sreg_r[0];
      SHIFT:   pad_data_s = ~sreg_r[0];
      DONE:    pad_data_s = 1'b0;
      default: pad_data_s = 1'b1;
    endcase
  end

  // console-presence timeout, saturating at TIMEOUT_CYCLES
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_r   <= '0;
      connected_r <= 1'b0;
    end else if (latch_rise_s) begin
      tmo_cnt_r   <= '0;
      connected_r <= 1'b1;
    end else if (tmo_cnt_r != TMO_MAX) begin
      tmo_cnt_r   <= tmo_cnt_r + TMO_W'(1);
      connected_r <= connected_r & ((tmo_cnt_r + TMO_W'(1)) != TMO_MAX);
    end else begin
      tmo_cnt_r   <= tmo_cnt_r;
      connected_r <= 1'b0;
    end
  end

  assign pad_if.pad_data    = pad_data_r;
  assign pad_if.poll_strobe = poll_strobe_r;
  assign pad_if.connected   = connected_r;
endmodule

// File: tb/tb_pad_serial_emulator.sv
// Directed bench for pad_serial_emulator: stimulus pushes expected wire bits,
// a monitor pops them whenever the console would sample pad_data.
module tb_pad_serial_emulator;
  import pad_pkg::*;

  localparam int unsigned MB  = 16;
  localparam int unsigned SS  = 2;
  localparam int unsigned TMO = 100;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pad_serial_emulator_if #(.MAX_BITS(MB)) pif ();

  pad_serial_emulator #(
    .MAX_BITS       (MB),
    .SYNC_STAGES    (SS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .pad_if (pif)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic        exp_q [$];
  int          strobe_cnt = 0;
  int          exp_strobes = 0;
  logic        mon_en = 1'b0;
  logic [MB-1:0] exp_btn = '0;
  int          exp_len = 8;
  int          exp_idx = 0;
  logic        in_latch = 1'b0;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_wire(input int idx);
    if (idx >= exp_len) return 1'b0;
    else return ~exp_btn[idx];
  endfunction

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // all stimulus tasks start and end on a falling clk edge
  task automatic latch_rise(input pad_mode_e m, input logic [MB-1:0] b);
    pif.mode    = m;
    pif.buttons = b;
    exp_len     = (m == PAD_SNES) ? 16 : 8;
    exp_btn     = (m == PAD_SNES) ? b : (b & 16'h00FF);
    exp_idx     = 0;
    in_latch    = 1'b1;
    pif.pad_latch = 1'b1;
  endtask

  task automatic latch_fall();
    exp_q.push_back(exp_wire(0));
    in_latch      = 1'b0;
    pif.pad_latch = 1'b0;
  endtask

  task automatic latch_pulse(input pad_mode_e m, input logic [MB-1:0] b);
    latch_rise(m, b);
    ticks(8);
    latch_fall();
    ticks(6);
  endtask

  task automatic clk_pulse();
    pif.pad_clock = 1'b1;
    if (in_latch) begin
      exp_q.push_back(~exp_btn[0]);
    end else begin
      if (exp_idx < exp_len) begin
        exp_idx++;
        if (exp_idx == exp_len) exp_strobes++;
      end
      exp_q.push_back(exp_wire(exp_idx));
    end
    ticks(8);
    pif.pad_clock = 1'b0;
    ticks(8);
  endtask

  always @(posedge clk) begin
    if (pif.poll_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  // monitor: console samples pad_data on latch fall and on each clock fall
  initial begin
    logic e;
    wait (mon_en);
    forever begin
      @(negedge pif.pad_latch or negedge pif.pad_clock);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pad_data: unexpected sample, got %b at %0t", pif.pad_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("pad_data", pif.pad_data, e);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pif.mode      = PAD_NES;
    pif.buttons   = '0;
    pif.pad_latch = 1'b0;
    pif.pad_clock = 1'b0;
    ticks(4);
    check("reset pad_data", pif.pad_data, 1'b1);
    check("reset poll_strobe", pif.poll_strobe, 1'b0);
    check("reset connected", pif.connected, 1'b0);
    reset = 1'b0;
    mon_en = 1'b1;
    ticks(4);

    // connected timeout with TIMEOUT_CYCLES = 100
    latch_rise(PAD_NES, 16'h0009);
    ticks(2);
    check("connected before sync", pif.connected, 1'b0);
    ticks(1);
    check("connected after latch", pif.connected, 1'b1);
    ticks(5);
    latch_fall();
    ticks(94);
    check("connected at count 99", pif.connected, 1'b1);
    ticks(1);
    check("connected at count 100", pif.connected, 1'b0);
    ticks(17);
    check("connected stays low", pif.connected, 1'b0);

    // NES frame A+Start; the new latch also re-asserts connected
    latch_rise(PAD_NES, 16'h0009);
    ticks(3);
    check("connected re-asserted", pif.connected, 1'b1);
    ticks(5);
    latch_fall();
    ticks(6);
    repeat (8) clk_pulse();
    check_int("nes strobe", strobe_cnt, exp_strobes);
    clk_pulse();
    check_int("done ignores clock", strobe_cnt, 1);

    // SNES frame B,A,X,L,R
    latch_pulse(PAD_SNES, 16'h0F01);
    repeat (15) clk_pulse();
    check_int("snes no early strobe", strobe_cnt, 1);
    clk_pulse();
    check_int("snes strobe", strobe_cnt, exp_strobes);

    // console clock while latched is ignored
    latch_rise(PAD_NES, 16'h0001);
    ticks(6);
    repeat (3) clk_pulse();
    latch_fall();
    ticks(6);
    repeat (8) clk_pulse();
    check_int("latch clock strobe", strobe_cnt, exp_strobes);

    // abort a SNES frame after 5 bits, restart as NES; mode change mid-frame ignored
    latch_pulse(PAD_SNES, 16'h0F01);
    repeat (5) clk_pulse();
    latch_pulse(PAD_NES, 16'h0F5A);
    check_int("abort no strobe", strobe_cnt, 3);
    pif.mode = PAD_SNES;
    repeat (8) clk_pulse();
    check_int("restart strobe", strobe_cnt, exp_strobes);

    // reset in the middle of SHIFT
    latch_pulse(PAD_NES, 16'h0033);
    repeat (3) clk_pulse();
    reset = 1'b1;
    ticks(1);
    check("midreset pad_data", pif.pad_data, 1'b1);
    check("midreset connected", pif.connected, 1'b0);
    check("midreset poll_strobe", pif.poll_strobe, 1'b0);
    reset = 1'b0;
    ticks(4);
    latch_pulse(PAD_SNES, 16'h0A0F);
    repeat (16) clk_pulse();
    check_int("post reset strobe", strobe_cnt, exp_strobes);
    check_int("post reset total", strobe_cnt, 5);

    ticks(4);
    check_int("queue drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
